// File: rtl/l1_pool_l2.sv
// Layer-2 2x2/stride-2 pooling over the Layer-1 map in the shared feature memory.
// Define AVG_POOL_EN for rounded average pooling; the default build is signed max pooling.
module l1_pool_l2 #(
   parameter int         DATA_W  = 20,
   parameter int         IN_W    = 32,
   parameter logic [2:0] SRC_SEL = 3'd3,
   parameter logic [2:0] DST_SEL = 3'd5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     crd,
   output logic [11:0]              caddr_rd,
   input  logic signed [DATA_W-1:0] cdata_rd,
   output logic                     cwr,
   output logic [11:0]              caddr_wr,
   output logic signed [DATA_W-1:0] cdata_wr,
   output logic [2:0]               csel
);

   localparam int AW = $clog2(IN_W);
   localparam int OW = AW - 1;

   typedef enum logic [2:0] {S_IDLE, S_RD, S_LAST, S_WR, S_FIN} state_t;

   state_t          state_q, state_d;
   logic [1:0]      k_q, k_d;
   logic [OW-1:0]   x_q, y_q, x_d, y_d;
   logic            last_out;

   logic            busy_d, done_d, crd_d, cwr_d;
   logic [2:0]      csel_d;
   logic [11:0]     caddr_rd_d, caddr_wr_d;

   assign last_out = (x_q == '1) && (y_q == '1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   // k_d is the read phase for the coming cycle; indices advance as WR retires.
   always_comb begin
      state_d = state_q;
      k_d     = '0;
      x_d     = x_q;
      y_d     = y_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_RD;
         S_RD: begin
            k_d = k_q + 2'd1;
            if (k_q == 2'd3) state_d = S_LAST;
         end
         S_LAST: state_d = S_WR;
         S_WR: begin
            x_d = x_q + 1'b1;
            if (x_q == '1) y_d = y_q + 1'b1;
            state_d = last_out ? S_FIN : S_RD;
         end
         S_FIN: begin
            state_d = S_IDLE;
            x_d     = '0;
            y_d     = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so that they leave flops directly.
   always_comb begin
      crd_d      = (state_d == S_RD);
      cwr_d      = (state_d == S_WR);
      busy_d     = (state_d == S_RD) || (state_d == S_LAST) || (state_d == S_WR);
      done_d     = (state_d == S_FIN);
      csel_d     = crd_d ? SRC_SEL : (cwr_d ? DST_SEL : 3'd0);
      caddr_rd_d = crd_d ? 12'({y_d, k_d[1], x_d, k_d[0]}) : caddr_rd;
      caddr_wr_d = cwr_d ? 12'({y_d, x_d}) : caddr_wr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         crd      <= 1'b0;
         cwr      <= 1'b0;
         csel     <= 3'd0;
         caddr_rd <= '0;
         caddr_wr <= '0;
      end else begin
         busy     <= busy_d;
         done     <= done_d;
         crd      <= crd_d;
         cwr      <= cwr_d;
         csel     <= csel_d;
         caddr_rd <= caddr_rd_d;
         caddr_wr <= caddr_wr_d;
      end
   end

`ifdef AVG_POOL_EN
   localparam int SW = DATA_W + 2;
   logic signed [SW-1:0]     acc_q, first, merged;
   logic signed [DATA_W-1:0] result;
   assign first  = SW'(cdata_rd);
   assign merged = acc_q + first;
   assign result = DATA_W'((merged + SW'(2)) >>> 2);
`else
   logic signed [DATA_W-1:0] acc_q, first, merged, result;
   assign first  = cdata_rd;
   // Strict compare: on a tie the earlier word is kept.
   assign merged = (cdata_rd > acc_q) ? cdata_rd : acc_q;
   assign result = merged;
`endif

   // Word k arrives while phase k+1 is on the bus; the 4th word lands in LAST.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q    <= '0;
         cdata_wr <= '0;
      end else begin
         if (state_q == S_RD && k_q != 2'd0)
            acc_q <= (k_q == 2'd1) ? first : merged;
         if (state_q == S_LAST)
            cdata_wr <= result;
      end
   end

endmodule

// File: tb/tb_l1_pool_l2.sv
// Randomized self-checking bench for l1_pool_l2 with a memory model and pooling reference.
module tb_l1_pool_l2;
   localparam int DW = 20;

   logic                 clk = 1'b0;
   logic                 reset, start;
   logic                 busy, done, crd, cwr;
   logic [11:0]          caddr_rd, caddr_wr;
   logic signed [DW-1:0] cdata_rd, cdata_wr;
   logic [2:0]           csel;

   always #5 clk = ~clk;

   l1_pool_l2 dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
      .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
   );

   logic signed [DW-1:0] l1 [0:1023];
   logic signed [DW-1:0] l2 [0:255];
   logic signed [DW-1:0] prev [0:255];
   int wr_cnt = 0, done_cnt = 0, overlap_cnt = 0, sel_err = 0;
   int tests = 0, fails = 0;

   // Memory with one-cycle read latency, write capture and bus-rule monitors
   always @(posedge clk) begin
      cdata_rd <= crd ? l1[caddr_rd[9:0]] : DW'($urandom);
      if (cwr) begin
         l2[caddr_wr[7:0]] <= cdata_wr;
         wr_cnt <= wr_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (crd && cwr) overlap_cnt <= overlap_cnt + 1;
      if ((crd && csel != 3'd3) || (cwr && csel != 3'd5) || (!crd && !cwr && csel != 3'd0))
         sel_err <= sel_err + 1;
   end

   function automatic logic signed [DW-1:0] ref_pool(int oy, int ox);
      int v[4];
      int r;
      v[0] = l1[(2*oy)*32 + 2*ox];
      v[1] = l1[(2*oy)*32 + 2*ox + 1];
      v[2] = l1[(2*oy+1)*32 + 2*ox];
      v[3] = l1[(2*oy+1)*32 + 2*ox + 1];
`ifdef AVG_POOL_EN
      r = (v[0] + v[1] + v[2] + v[3] + 2) >>> 2;
`else
      r = v[0];
      for (int i = 1; i < 4; i++) if (v[i] > r) r = v[i];
`endif
      return DW'(r);
   endfunction

   function automatic int map_errs(output int first_bad);
      int n = 0;
      first_bad = -1;
      for (int i = 0; i < 256; i++)
         if (l2[i] !== ref_pool(i / 16, i % 16)) begin
            if (first_bad < 0) first_bad = i;
            n++;
         end
      return n;
   endfunction

   task automatic fill_random;
      int t;
      for (int a = 0; a < 1024; a++) begin
         t = $urandom_range(0, 7);
         case ($urandom_range(0, 2))
            0:       l1[a] = DW'(t - 4);
            1:       l1[a] = DW'($urandom);
            default: l1[a] = DW'(int'($urandom_range(0, 2000)) - 1000);
         endcase
      end
   endtask

   task automatic pulse_start;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done(input int c0, output int dc);
      int c = c0;
      while (!done && c < 3000) begin
         @(negedge clk);
         c++;
      end
      dc = done ? c : -1;
   endtask

   task automatic run_full(output int dc, output int wrs, output int dns);
      int w0 = wr_cnt, d0 = done_cnt;
      pulse_start;
      wait_done(1, dc);
      repeat (3) @(negedge clk);
      wrs = wr_cnt - w0;
      dns = done_cnt - d0;
   endtask

   task automatic check_run(input string tag, input int dc, input int wrs, input int dns);
      int e, fb;
      tests++;
      if (dc !== 1537) begin fails++; $display("FAIL %s done_cycle got %0d exp 1537", tag, dc); end
      tests++;
      if (wrs !== 256) begin fails++; $display("FAIL %s write_count got %0d exp 256", tag, wrs); end
      tests++;
      if (dns !== 1) begin fails++; $display("FAIL %s done_pulses got %0d exp 1", tag, dns); end
      e = map_errs(fb);
      tests++;
      if (e !== 0) begin
         fails++;
         $display("FAIL %s map %0d bad, first L2[%0d] got %0d exp %0d", tag, e, fb,
                  l2[fb], ref_pool(fb / 16, fb % 16));
      end
   endtask

   task automatic test_reset;
      logic [58:0] got;
      reset = 1'b1; start = 1'b0;
      @(negedge clk); @(negedge clk);
      got = {busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr};
      tests++;
      if (got !== 59'd0) begin fails++; $display("FAIL reset_outputs got %h exp 0", got); end
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if ({busy, crd, cwr} !== 3'b000) begin fails++; $display("FAIL idle_quiet got %b exp 000", {busy, crd, cwr}); end
   endtask

   task automatic test_ramp;
      int dc, wrs, dns;
      logic signed [DW-1:0] e0, e255;
`ifdef AVG_POOL_EN
      e0 = 17; e255 = 1007;
`else
      e0 = 33; e255 = 1023;
`endif
      for (int a = 0; a < 1024; a++) l1[a] = DW'(a);
      run_full(dc, wrs, dns);
      check_run("ramp", dc, wrs, dns);
      tests++;
      if (l2[0] !== e0) begin fails++; $display("FAIL ramp_L2_0 got %0d exp %0d", l2[0], e0); end
      tests++;
      if (l2[255] !== e255) begin fails++; $display("FAIL ramp_L2_255 got %0d exp %0d", l2[255], e255); end
   endtask

   task automatic test_protocol;
      int ov0 = overlap_cnt, se0 = sel_err, w0 = wr_cnt, d0 = done_cnt;
      int dc;
      logic [11:0] ra [4];
      logic [16:0] got, exp;
      ra[0] = 12'd0; ra[1] = 12'd1; ra[2] = 12'd32; ra[3] = 12'd33;
      fill_random;
      pulse_start;
      for (int c = 1; c <= 6; c++) begin
         got = {crd, cwr, csel, caddr_rd};
         if (c <= 4)      exp = {1'b1, 1'b0, 3'd3, ra[c-1]};
         else if (c == 5) exp = {1'b0, 1'b0, 3'd0, ra[3]};
         else             exp = {1'b0, 1'b1, 3'd5, ra[3]};
         tests++;
         if (got !== exp) begin fails++; $display("FAIL proto_cycle%0d got %h exp %h", c, got, exp); end
         if (c == 6) begin
            tests++;
            if ({caddr_wr, cdata_wr} !== {12'd0, ref_pool(0, 0)}) begin
               fails++;
               $display("FAIL proto_first_write got addr %0d data %0d exp addr 0 data %0d",
                        caddr_wr, cdata_wr, ref_pool(0, 0));
            end
         end else @(negedge clk);
      end
      wait_done(6, dc);
      repeat (3) @(negedge clk);
      check_run("protocol", dc, wr_cnt - w0, done_cnt - d0);
      tests++;
      if (overlap_cnt - ov0 !== 0) begin fails++; $display("FAIL rd_wr_overlap got %0d exp 0", overlap_cnt - ov0); end
      tests++;
      if (sel_err - se0 !== 0) begin fails++; $display("FAIL csel_rule got %0d exp 0", sel_err - se0); end
   endtask

   task automatic test_negatives;
      int dc, wrs, dns;
      logic signed [DW-1:0] ex [4];
`ifdef AVG_POOL_EN
      ex[0] = -6; ex[1] = -1; ex[2] = 3; ex[3] = -2;
`else
      ex[0] = -3; ex[1] = 0;  ex[2] = 4; ex[3] = -1;
`endif
      fill_random;
      l1[0] = -5; l1[1] = -3; l1[32] = -9; l1[33] = -7;
      l1[2] = 0;  l1[3] = -1; l1[34] = -1; l1[35] = -1;
      l1[4] = 1;  l1[5] = 2;  l1[36] = 3;  l1[37] = 4;
      l1[6] = -1; l1[7] = -2; l1[38] = -2; l1[39] = -2;
      run_full(dc, wrs, dns);
      check_run("negatives", dc, wrs, dns);
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (l2[i] !== ex[i]) begin fails++; $display("FAIL neg_block%0d got %0d exp %0d", i, l2[i], ex[i]); end
      end
   endtask

   task automatic test_start_while_busy;
      int c, dc, wrs, dns, diff;
      int w0 = wr_cnt, d0 = done_cnt;
      fill_random;
      pulse_start;
      c = 1;
      while (c < 100) begin @(negedge clk); c++; end
      start = 1'b1;
      @(negedge clk); c++;
      start = 1'b0;
      wait_done(c, dc);
      repeat (3) @(negedge clk);
      check_run("busy_start", dc, wr_cnt - w0, done_cnt - d0);
      for (int i = 0; i < 256; i++) prev[i] = l2[i];
      run_full(dc, wrs, dns);
      check_run("rerun", dc, wrs, dns);
      diff = 0;
      for (int i = 0; i < 256; i++) if (l2[i] !== prev[i]) diff++;
      tests++;
      if (diff !== 0) begin fails++; $display("FAIL rerun_identical got %0d diffs exp 0", diff); end
   endtask

   task automatic test_reset_mid;
      int c, w0, dc, wrs, dns;
      fill_random;
      pulse_start;
      c = 1;
      while (c < 700) begin @(negedge clk); c++; end
      reset = 1'b1;
      #1;
      tests++;
      if ({crd, cwr, busy} !== 3'b000) begin fails++; $display("FAIL midreset_drop got %b exp 000", {crd, cwr, busy}); end
      w0 = wr_cnt;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL midreset_writes got %0d exp 0", wr_cnt - w0); end
      for (int i = 0; i < 256; i++) l2[i] = 'x;
      run_full(dc, wrs, dns);
      check_run("after_reset", dc, wrs, dns);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      test_reset;
      test_ramp;
      test_protocol;
      test_negatives;
      test_start_while_busy;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/l1_pool_l2.md
Name: l1_pool_l2

Overview:
Layer-2 stage downstream of the convolution/max-pool engine. After the Layer-1 map is complete, this block reads it from the shared feature memory: 32x32 signed 20-bit words, csel bank 3'd3. It performs 2x2, stride-2 pooling and writes a 16x16 Layer-2 map to bank 3'd5. A start/busy/done handshake lets the top-level sequencer launch it once the upstream stage finishes.

Parameters:
DATA_W, 20, feature word width (signed)
IN_W, 32, input map width/height (power of two, >=4)
SRC_SEL, 3'd3, csel value for Layer-1 reads
DST_SEL, 3'd5, csel value for Layer-2 writes

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
start  input  1  one-cycle launch pulse, sampled in IDLE only
busy  output  1  high from cycle after accepted start until done
done  output  1  one-cycle pulse after the final write
crd  output  1  memory read strobe
caddr_rd  output  12  read address, {y[4:0],x[4:0]} zero-extended
cdata_rd  input  DATA_W  signed read data, one-cycle latency
cwr  output  1  memory write strobe
caddr_wr  output  12  write address, {Y[3:0],X[3:0]} zero-extended
cdata_wr  output  DATA_W  signed write data
csel  output  3  bank select: SRC_SEL during reads, DST_SEL during writes, 0 otherwise

Behaviour:
- Reset (async): state=IDLE. busy, done, crd, cwr = 0. caddr_rd, caddr_wr, cdata_wr, csel = 0. Output indices X=Y=0.
- All outputs registered. Read protocol: crd=1 with caddr_rd=A in cycle N. cdata_rd holds mem[A] and is sampled at the edge ending cycle N+1.
- FSM: IDLE -> RD -> LAST -> WR -> (RD | FIN) -> IDLE.
- IDLE: on start=1, go to RD and set busy=1. start in any other state is ignored.
- RD: 4 cycles, sub-counter k=0..3. crd=1, csel=SRC_SEL. Addresses, in order: (2Y,2X), (2Y,2X+1), (2Y+1,2X), (2Y+1,2X+1).
  - The word for k=0 initialises the accumulator.
  - The words for k=1..3 are merged.
- LAST: 1 cycle. crd=0, csel=0. Captures and merges the 4th word.
- WR: 1 cycle. cwr=1, csel=DST_SEL, caddr_wr=Y*16+X, cdata_wr=pooled result.
  - Then X increments. When X=15: X=0 and Y increments.
  - If (X,Y)=(15,15): go to FIN, else go to RD.
- Merge: signed max, strict greater-than replaces. Ties keep the earlier value. No width growth.
- FIN: 1 cycle. done=1, busy=0, then IDLE. Indices are cleared to 0, so a new start re-runs from (0,0).
- Timing per output: 6 cycles.
  - First cwr is asserted 6 cycles after the start edge.
  - The full map takes 1536 cycles; done asserts on cycle 1537.
- In non-write cycles: cwr=0. caddr_wr and cdata_wr hold their last value.
- Reads and writes are never active in the same cycle.
- Reset mid-operation returns to IDLE immediately. No further crd/cwr. Partial Layer-2 contents are don't-care.
- Negative inputs are legal: the upstream ReLU produces non-negatives, but the block must not assume it.

Optional Feature:
AVG_POOL_EN
- Defined: merge is accumulate into a DATA_W+2 signed sum. Result = (sum + 2) >>> 2, arithmetic, round-half-up, truncated to DATA_W. Timing is unchanged.
- Undefined: signed max as above. No adder logic is instantiated.

Test Plan:
1. Ramp: L1[a]=a for a=0..1023, pulse start -> 256 writes. L2[Y*16+X] = (2Y+1)*32+2X+1; e.g. L2[0]=33, L2[255]=1023. done once at cycle 1537 after start.
2. Negatives: L1 block (0,0) = {-5,-3,-9,-7} -> L2[0] = -3. Block (0,1) = {0,-1,-1,-1} -> L2[1] = 0.
3. Protocol check on first output: crd high cycles 1-4, addresses 0,1,32,33, csel=3. cwr in cycle 6 with csel=5, caddr_wr=0. No overlap of crd and cwr anywhere.
4. start pulsed at cycle 100 while busy -> ignored. Exactly 256 writes, single done pulse. A second start after done reruns and produces identical results.
5. Assert reset at cycle 700 -> crd, cwr, busy drop 0 immediately. A fresh start then produces the full correct map from L2[0].
6. With AVG_POOL_EN: block {1,2,3,4} -> 3 (10+2=12, >>2 = 3). Block {-1,-2,-2,-2} -> -2 (-7+2=-5, >>>2 = -2).
